// File: rtl/tent_stream_decryptor_if.sv
`default_nettype none
// ============================================================================
//  Module      : tent_stream_decryptor_if
//  Description : Byte-stream bundle for the tent-map decryptor. It carries the
//                encrypted input stream (valid/ready) and the decrypted output
//                stream (valid/ready/last).
//  Revision    : 1.0  initial release
// ============================================================================
interface tent_stream_decryptor_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    // Source of encrypted bytes and sink of plaintext bytes
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    // Decryptor side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/tent_stream_decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : tent_stream_decryptor
//  Description : Regenerates the tent-map keystream from a shared seed and
//                ratio. It XORs the keystream onto encrypted pixel bytes, one
//                byte per pixel, with 1-cycle in->out latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tent_stream_decryptor #(
    parameter int BURN_IN = 64,
    parameter int LEN_W   = 24
) (
    input  wire logic              clk,
    input  wire logic              reset,      // synchronous, active-low
    input  wire logic              start,
    input  wire logic [31:0]       seed,
    input  wire logic [31:0]       ratio,
    input  wire logic [LEN_W-1:0]  frame_len,
    tent_stream_decryptor_if.slave s,
    output logic                   busy,
    output logic                   done
);

    localparam int          c_BURN_W    = (BURN_IN > 1) ? $clog2(BURN_IN) : 1;
    localparam logic [c_BURN_W-1:0] c_BURN_LAST = c_BURN_W'((BURN_IN > 0) ? BURN_IN - 1 : 0);
    localparam logic [31:0] c_SEED_ALT  = 32'h9E37_79B9;  // replaces seed 0, which is a fixed point

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         x_q, x_d;
    logic [31:0]         ratio_q, ratio_d;
    logic [LEN_W-1:0]    pixels_left_q, pixels_left_d;
    logic [c_BURN_W-1:0] burn_cnt_q, burn_cnt_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    logic [31:0] w_opnd;
    logic [63:0] w_prod;
    logic [63:0] w_shr;
    logic [31:0] w_f;
    logic        w_in_ready;
    logic        w_accept;

    // Tent step: fold the upper half, multiply by mu, rescale Q2.30 and saturate
    always_comb begin
        w_opnd = x_q[31] ? ~x_q : x_q;
        w_prod = {32'd0, ratio_q} * {32'd0, w_opnd};
        w_shr  = w_prod >> 30;
        w_f    = (w_shr > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : w_shr[31:0];
    end

    // Next-state, datapath updates and handshake decisions
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        ratio_d       = ratio_q;
        pixels_left_d = pixels_left_q;
        burn_cnt_d    = burn_cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        done          = 1'b0;

        // Stall-aware: a pending byte must drain before another is taken
        w_in_ready = (state_q == S_RUN) && (pixels_left_q != '0) &&
                     (!out_valid_q || s.out_ready);
        w_accept   = w_in_ready && s.in_valid;

        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = s.in_data ^ w_f[31:24];
            out_last_d  = (pixels_left_q == LEN_W'(1));
        end else if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d           = (seed == 32'd0) ? c_SEED_ALT : seed;
                    ratio_d       = ratio;
                    pixels_left_d = frame_len;
                    burn_cnt_d    = '0;
                    state_d       = (BURN_IN == 0) ? S_RUN : S_WARMUP;
                end
            end
            S_WARMUP: begin
                x_d = w_f;
                if (burn_cnt_q == c_BURN_LAST) begin
                    state_d = S_RUN;
                end else begin
                    burn_cnt_d = burn_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    x_d           = w_f;
                    pixels_left_d = pixels_left_q - 1'b1;
                    if (pixels_left_q == LEN_W'(1)) begin
                        state_d = S_FLUSH;
                    end
                end else if (pixels_left_q == '0) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!out_valid_q || s.out_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            ratio_q       <= '0;
            pixels_left_q <= '0;
            burn_cnt_q    <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            ratio_q       <= ratio_d;
            pixels_left_q <= pixels_left_d;
            burn_cnt_q    <= burn_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
        end
    end

    assign s.in_ready  = w_in_ready;
    assign s.out_data  = out_data_q;
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tent_stream_decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tent_stream_decryptor
//  Description : Directed bench for tent_stream_decryptor (BURN_IN=0). Frames
//                come from a table of hand-computed vectors. Hand-written
//                sequences cover stalls, empty frames and mid-frame reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tent_stream_decryptor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seed;
    logic [31:0] ratio;
    logic [23:0] frame_len;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    tent_stream_decryptor_if bus ();

    tent_stream_decryptor #(.BURN_IN(0), .LEN_W(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seed      (seed),
        .ratio     (ratio),
        .frame_len (frame_len),
        .s         (bus.slave),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One frame: bytes listed first-pixel-first in the MSBs
    typedef struct {
        logic [31:0] seed;
        logic [31:0] ratio;
        int          len;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs one frame from the table. Entered and left on a negedge.
    task automatic run_frame(input int vi, input bit stall);
        int          sent  = 0;
        int          got   = 0;
        int          dones = 0;
        int          cyc   = 0;
        bit          held  = 0;
        logic [7:0]  hold_d = 8'h00;
        logic [31:0] din   = vecs[vi].din;
        logic [31:0] dout  = vecs[vi].dout;
        int          len   = vecs[vi].len;

        seed      = vecs[vi].seed;
        ratio     = vecs[vi].ratio;
        frame_len = 24'(len);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;

        while (dones == 0 && cyc < 200) begin
            bus.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            bus.in_valid  = (sent < len) && (!stall || (cyc % 3 != 1));
            bus.in_data   = (sent < len) ? din[31 - 8*sent -: 8] : 8'h00;
            #1;
            if (held) begin
                check($sformatf("f%0d_stall_valid", vi), bus.out_valid, 1'b1);
                check($sformatf("f%0d_stall_data", vi), bus.out_data, hold_d);
            end
            held = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (got < len) begin
                    check($sformatf("f%0d_data%0d", vi, got), bus.out_data, dout[31 - 8*got -: 8]);
                    check($sformatf("f%0d_last%0d", vi, got), bus.out_last, (got == len - 1));
                end else begin
                    check($sformatf("f%0d_extra_beat", vi), 1'b1, 1'b0);
                end
                got++;
            end else if (bus.out_valid) begin
                held   = 1;
                hold_d = bus.out_data;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (done) dones++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check($sformatf("f%0d_done_count", vi), dones, 1);
        check($sformatf("f%0d_beats", vi), got, len);
        check($sformatf("f%0d_idle_busy", vi), busy, 1'b0);
        check($sformatf("f%0d_idle_done", vi), done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h4000_0000, 32'h8000_0000, 4, 32'h0000_0000, 32'h80FF_0000};
        vecs[1] = '{32'h4000_0000, 32'h8000_0000, 4, 32'h80FF_0000, 32'h0000_0000};
        vecs[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 32'hA500_0000, 32'h5A00_0000};
        vecs[3] = '{32'h0000_0000, 32'h8000_0000, 2, 32'h0000_0000, 32'hC378_0000};
        vecs[4] = '{32'h1234_5678, 32'h4000_0000, 3, 32'hFF0F_F000, 32'hED1D_E200};
        vecs[5] = '{32'hC000_0000, 32'h4000_0000, 2, 32'h0000_0000, 32'h3F3F_0000};

        // Reset state, with stray input present
        reset         = 1'b0;
        start         = 1'b0;
        seed          = '0;
        ratio         = '0;
        frame_len     = '0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  8'h00);
        check("rst_out_last",  bus.out_last,  1'b0);
        check("rst_busy",      busy,          1'b0);
        check("rst_done",      done,          1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;

        // Table of frames at full throughput
        for (int i = 0; i < 6; i++) run_frame(i, 1'b0);

        // Back-pressure and input gaps must not change the byte sequence
        run_frame(0, 1'b1);

        // Empty frame; a second start while running is ignored
        seed      = 32'h4000_0000;
        ratio     = 32'h8000_0000;
        frame_len = 24'd0;
        start     = 1'b1;
        @(negedge clk);
        frame_len = 24'd5;
        #1;
        check("t5_busy_run",   busy,          1'b1);
        check("t5_done_run",   done,          1'b0);
        check("t5_in_ready",   bus.in_ready,  1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t5_done",       done,          1'b1);
        check("t5_out_valid",  bus.out_valid, 1'b0);
        @(negedge clk);
        check("t5_done_clear", done,          1'b0);
        check("t5_idle",       busy,          1'b0);

        // Mid-frame reset after two pixels, then a clean replay
        seed          = 32'h4000_0000;
        ratio         = 32'h8000_0000;
        frame_len     = 24'd4;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_pre_valid", bus.out_valid, 1'b1);
        check("t6_pre_data",  bus.out_data,  8'hFF);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t6_in_ready",  bus.in_ready,  1'b0);
        check("t6_out_valid", bus.out_valid, 1'b0);
        check("t6_out_data",  bus.out_data,  8'h00);
        check("t6_out_last",  bus.out_last,  1'b0);
        check("t6_busy",      busy,          1'b0);
        check("t6_done",      done,          1'b0);
        reset = 1'b1;
        @(negedge clk);
        run_frame(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
